// File: rtl/cache_xfer_pkg.sv
// Shared types and size helpers for the cache <-> AXI block mover.
package cache_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

  function automatic int calc_beats(input int block_w, input int data_w);
    return block_w / data_w;
  endfunction

  function automatic int calc_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Beat slot of a byte address inside its block (used for wrap-order starts).
  function automatic int beat_offset(input longint unsigned addr, input int beat_bytes,
                                     input int beats);
    longint unsigned q;
    q = (addr / longint'(beat_bytes)) % longint'(beats);
    return int'(q);
  endfunction

endpackage

// File: rtl/cache_burst_transfer_beat_addr_gen.sv
// Block-aligned beat address generator: base, wrapping beat index and beat counter.
module beat_addr_gen
  import cache_xfer_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BEATS          = 16,
  parameter int BEAT_BYTES     = 4,
  parameter int BLOCK_BYTES    = 64,
  parameter int IDX_W          = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      load_i,
  input  logic                      advance_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [IDX_W-1:0]          load_idx_i,
  output logic [IDX_W-1:0]          idx_o,
  output logic                      last_o,
  output logic [AXI_ADDR_WIDTH-1:0] addr_o
);

  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;

  always_comb begin
    base_d = base_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      base_d = addr_i & ~AXI_ADDR_WIDTH'(BLOCK_BYTES - 1);
      idx_d  = load_idx_i;
      cnt_d  = '0;
    end else if (advance_i) begin
      // Explicit wrap so non-power-of-two beat counts stay inside the block.
      idx_d = (idx_q == IDX_W'(BEATS - 1)) ? '0 : idx_q + IDX_W'(1);
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      base_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (cnt_q == IDX_W'(BEATS - 1));
  assign addr_o = base_q + AXI_ADDR_WIDTH'(idx_q) * AXI_ADDR_WIDTH'(BEAT_BYTES);

endmodule

// File: rtl/cache_burst_transfer.sv
// Moves one cache block to/from an AXI beat channel (refill = READ, evict = WRITE).
// Optional CACHE_XFER_CRITICAL_WORD_FIRST_EN: refills start at the requested beat.
module cache_burst_transfer
  import cache_xfer_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      start_read_i,
  input  logic                      start_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_cache_i,
  input  logic [BLOCK_WIDTH-1:0]    data_block_cache_i,
  input  logic                      rd_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] rd_data_i,
  output logic                      rd_ready_o,
  output logic                      wr_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] wr_data_o,
  input  logic                      wr_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] addr_axi_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [BLOCK_WIDTH-1:0]    data_block_cache_o
);

  localparam int BEATS       = calc_beats(BLOCK_WIDTH, AXI_DATA_WIDTH);
  localparam int IDX_W       = calc_idx_w(BEATS);
  localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BLOCK_BYTES = BLOCK_WIDTH / 8;

  xfer_state_t state_q;
  logic        rd_ready_q, wr_valid_q, busy_q, done_q;
  logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] blk_q;

  logic [IDX_W-1:0] idx, rd_first_idx, load_idx;
  logic             last, load, rd_beat, wr_beat;
  logic [AXI_DATA_WIDTH-1:0] wr_data;

`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
  assign rd_first_idx = IDX_W'(beat_offset(64'(addr_cache_i), BEAT_BYTES, BEATS));
`else
  assign rd_first_idx = '0;
`endif

  assign load     = (state_q == IDLE) && (start_write_i || start_read_i);
  assign load_idx = start_write_i ? '0 : rd_first_idx;
  assign rd_beat  = rd_valid_i && rd_ready_q;
  assign wr_beat  = wr_valid_q && wr_ready_i;

  beat_addr_gen #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .BEATS         (BEATS),
    .BEAT_BYTES    (BEAT_BYTES),
    .BLOCK_BYTES   (BLOCK_BYTES),
    .IDX_W         (IDX_W)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .load_i    (load),
    .advance_i (rd_beat || wr_beat),
    .addr_i    (addr_cache_i),
    .load_idx_i(load_idx),
    .idx_o     (idx),
    .last_o    (last),
    .addr_o    (addr_axi_o)
  );

  // Handshake flags are registered alongside the state so they change with it.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      rd_ready_q <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_write_i) begin
            state_q    <= WRITE;
            wr_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (start_read_i) begin
            state_q    <= READ;
            rd_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        READ: if (rd_beat && last) begin
          state_q    <= DONE;
          rd_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
        end
        WRITE: if (wr_beat && last) begin
          state_q    <= DONE;
          wr_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      blk_q <= '0;
    end else if (load && start_write_i) begin
      blk_q <= data_block_cache_i;
    end else if (rd_beat) begin
      for (int k = 0; k < BEATS; k++)
        if (idx == IDX_W'(k)) blk_q[k] <= rd_data_i;
    end
  end

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < BEATS; k++)
      if (idx == IDX_W'(k)) wr_data = blk_q[k];
  end

  assign rd_ready_o         = rd_ready_q;
  assign wr_valid_o         = wr_valid_q;
  assign wr_data_o          = wr_data;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign data_block_cache_o = blk_q;

endmodule

// File: tb/tb_cache_burst_transfer.sv
// Directed bench: reset, abort, refill, evict with backpressure, start priority, size sweep.
module tb_cache_burst_transfer;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main instance: 32-bit beats, 512-bit block.
  logic        start_rd, start_wr, rd_valid, rd_ready, wr_valid, wr_ready, busy, done;
  logic [63:0] addr_c, addr_axi;
  logic [511:0] blk_in, blk_out;
  logic [31:0] rd_data, wr_data;

  cache_burst_transfer u_dut (
    .clk_i(clk), .arst_ni(arst_n), .start_read_i(start_rd), .start_write_i(start_wr),
    .addr_cache_i(addr_c), .data_block_cache_i(blk_in), .rd_valid_i(rd_valid),
    .rd_data_i(rd_data), .rd_ready_o(rd_ready), .wr_valid_o(wr_valid), .wr_data_o(wr_data),
    .wr_ready_i(wr_ready), .addr_axi_o(addr_axi), .busy_o(busy), .done_o(done),
    .data_block_cache_o(blk_out)
  );

  // Sweep instance: 64-bit beats, 256-bit block, 32-bit address.
  logic        b_start_rd, b_start_wr, b_rd_valid, b_rd_ready, b_wr_valid, b_wr_ready, b_busy, b_done;
  logic [31:0] b_addr_c, b_addr_axi;
  logic [255:0] b_blk_in, b_blk_out;
  logic [63:0] b_rd_data, b_wr_data;

  cache_burst_transfer #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .BLOCK_WIDTH(256)) u_dut_b (
    .clk_i(clk), .arst_ni(arst_n), .start_read_i(b_start_rd), .start_write_i(b_start_wr),
    .addr_cache_i(b_addr_c), .data_block_cache_i(b_blk_in), .rd_valid_i(b_rd_valid),
    .rd_data_i(b_rd_data), .rd_ready_o(b_rd_ready), .wr_valid_o(b_wr_valid), .wr_data_o(b_wr_data),
    .wr_ready_i(b_wr_ready), .addr_axi_o(b_addr_axi), .busy_o(b_busy), .done_o(b_done),
    .data_block_cache_o(b_blk_out)
  );

  // Single-beat instance: block width equals beat width.
  logic        c_start_rd, c_start_wr, c_rd_valid, c_rd_ready, c_wr_valid, c_wr_ready, c_busy, c_done;
  logic [31:0] c_addr_c, c_addr_axi, c_blk_in, c_blk_out, c_rd_data, c_wr_data;

  cache_burst_transfer #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .BLOCK_WIDTH(32)) u_dut_c (
    .clk_i(clk), .arst_ni(arst_n), .start_read_i(c_start_rd), .start_write_i(c_start_wr),
    .addr_cache_i(c_addr_c), .data_block_cache_i(c_blk_in), .rd_valid_i(c_rd_valid),
    .rd_data_i(c_rd_data), .rd_ready_o(c_rd_ready), .wr_valid_o(c_wr_valid), .wr_data_o(c_wr_data),
    .wr_ready_i(c_wr_ready), .addr_axi_o(c_addr_axi), .busy_o(c_busy), .done_o(c_done),
    .data_block_cache_o(c_blk_out)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [511:0] exp_blk;
  int first, beat, cyc;

  initial begin
    arst_n = 1'b0;
    {start_rd, start_wr, rd_valid, wr_ready} = '0;
    addr_c = '0; blk_in = '0; rd_data = '0;
    {b_start_rd, b_start_wr, b_rd_valid, b_wr_ready} = '0;
    b_addr_c = '0; b_blk_in = '0; b_rd_data = '0;
    {c_start_rd, c_start_wr, c_rd_valid, c_wr_ready} = '0;
    c_addr_c = '0; c_blk_in = '0; c_rd_data = '0;

    #12;
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_rd_ready", 512'(rd_ready), 512'(0));
    chk("rst_wr_valid", 512'(wr_valid), 512'(0));
    chk("rst_addr", 512'(addr_axi), 512'(0));
    chk("rst_block", blk_out, 512'(0));
    chk("rst_wr_data", 512'(wr_data), 512'(0));
    tick();
    arst_n = 1'b1;

    // Abort a refill after 5 beats with reset.
    start_rd = 1'b1; addr_c = 64'h1000;
    tick();
    start_rd = 1'b0;
    chk("abort_rd_ready", 512'(rd_ready), 512'(1));
    chk("abort_busy", 512'(busy), 512'(1));
    chk("abort_addr0", 512'(addr_axi), 512'(64'h1000));
    rd_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      rd_data = 32'h55 + 32'(j);
      tick();
    end
    rd_valid = 1'b0;
    chk("abort_addr5", 512'(addr_axi), 512'(64'h1014));
    arst_n = 1'b0;
    #1;
    chk("abort_rd_ready0", 512'(rd_ready), 512'(0));
    chk("abort_busy0", 512'(busy), 512'(0));
    chk("abort_addr_clr", 512'(addr_axi), 512'(0));
    chk("abort_block_clr", blk_out, 512'(0));
    tick();
    chk("abort_no_done", 512'(done), 512'(0));
    arst_n = 1'b1;
    tick();

    // Refill at 0x1234, beats 0xA0.. back-to-back.
`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
    first = 13;
`else
    first = 0;
`endif
    start_rd = 1'b1; addr_c = 64'h1234;
    tick();
    start_rd = 1'b0; rd_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("rf_addr%0d", j), 512'(addr_axi), 512'(64'h1200 + 64'(((first + j) % 16) * 4)));
      chk($sformatf("rf_done_lo%0d", j), 512'(done), 512'(0));
      rd_data = 32'hA0 + 32'(j);
      tick();
    end
    for (int k = 0; k < 16; k++) exp_blk[k*32 +: 32] = 32'hA0 + 32'((k - first + 16) % 16);
    chk("rf_done", 512'(done), 512'(1));
    chk("rf_busy_done", 512'(busy), 512'(0));
    chk("rf_rd_ready_done", 512'(rd_ready), 512'(0));
    chk("rf_block", blk_out, exp_blk);
    rd_data = 32'hFF;
    tick();
    chk("rf_done_pulse", 512'(done), 512'(0));
    tick();
    rd_valid = 1'b0;
    chk("idle_beat_ignored", blk_out, exp_blk);

    // Evict with backpressure; both starts high, write must win.
    for (int k = 0; k < 16; k++) blk_in[k*32 +: 32] = 32'(k);
    start_wr = 1'b1; start_rd = 1'b1; addr_c = 64'h2040;
    tick();
    start_wr = 1'b0;
    beat = 0; cyc = 0;
    while (beat < 16 && cyc < 100) begin
      chk("ev_wr_valid", 512'(wr_valid), 512'(1));
      chk("ev_rd_ready", 512'(rd_ready), 512'(0));
      chk("ev_done_lo", 512'(done), 512'(0));
      chk($sformatf("ev_data%0d", beat), 512'(wr_data), 512'(beat));
      chk($sformatf("ev_addr%0d", beat), 512'(addr_axi), 512'(64'h2040 + 64'(beat * 4)));
      wr_ready = (cyc % 3 == 0);
      tick();
      if (wr_ready) beat++;
      cyc++;
    end
    wr_ready = 1'b0;
    chk("ev_beats", 512'(beat), 512'(16));
    chk("ev_done", 512'(done), 512'(1));
    chk("ev_wr_valid_done", 512'(wr_valid), 512'(0));
    chk("ev_block_kept", blk_out, blk_in);
    chk("ev_rd_ready_done", 512'(rd_ready), 512'(0));
    tick();
    chk("ev_done_pulse", 512'(done), 512'(0));
    chk("ev_idle_rd_ready", 512'(rd_ready), 512'(0));
    tick();
    chk("pending_read_taken", 512'(rd_ready), 512'(1));
    start_rd = 1'b0;
    arst_n = 1'b0;
    #1;
    chk("abort2_busy", 512'(busy), 512'(0));
    tick();
    arst_n = 1'b1;
    tick();

    // 64-bit beats, 256-bit block: 4 beats, step 8.
    for (int k = 0; k < 4; k++) b_blk_in[k*64 +: 64] = 64'h0100_0000_0000_0000 + 64'(k);
    b_start_wr = 1'b1; b_addr_c = 32'h48;
    tick();
    b_start_wr = 1'b0; b_wr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("b_addr%0d", j), 512'(b_addr_axi), 512'(32'h40 + 32'(j * 8)));
      chk($sformatf("b_data%0d", j), 512'(b_wr_data), 512'(64'h0100_0000_0000_0000 + 64'(j)));
      chk("b_done_lo", 512'(b_done), 512'(0));
      tick();
    end
    b_wr_ready = 1'b0;
    chk("b_done", 512'(b_done), 512'(1));
    chk("b_busy", 512'(b_busy), 512'(0));

    // Single-beat block.
    c_start_rd = 1'b1; c_addr_c = 32'h7;
    tick();
    c_start_rd = 1'b0;
    chk("c_rd_ready", 512'(c_rd_ready), 512'(1));
    chk("c_addr", 512'(c_addr_axi), 512'(32'h4));
    c_rd_valid = 1'b1; c_rd_data = 32'hDEADBEEF;
    tick();
    c_rd_valid = 1'b0;
    chk("c_done", 512'(c_done), 512'(1));
    chk("c_block", 512'(c_blk_out), 512'(32'hDEADBEEF));
    tick();
    chk("c_done_pulse", 512'(c_done), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
